// File: rtl/alu_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_mux_pkg
// Brief   : Shared definitions for the registered one-hot ALU result mux:
//           mode encodings and a select-vector classification helper.
// Revision: 1.0 - initial release
// ============================================================================
package alu_mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Population class of a select vector
  typedef enum logic [1:0] {
    OH_ZERO  = 2'd0,
    OH_ONE   = 2'd1,
    OH_MULTI = 2'd2
  } oh_class_e;

  // Classify a (zero-extended) select vector as empty, one-hot or multi-hot
  function automatic oh_class_e is_onehot(input logic [31:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + int'(v[i]);
    end
    if (cnt == 0)      return OH_ZERO;
    else if (cnt == 1) return OH_ONE;
    else               return OH_MULTI;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
// Module  : rr_grant
// Brief   : Combinational rotating-priority arbiter. Grants the first set
//           request at or above the pointer, wrapping past the top channel.
// Revision: 1.0 - initial release
// ============================================================================
module rr_grant #(
  parameter int NUM_CH = 16,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o,
  output logic              any_grant_o
);

  // Scan channels ptr, ptr+1, ... with wrap; the first asserted request wins
  always_comb begin
    int j;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    j           = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (req_i[j] && !any_grant_o) begin
        grant_o[j]  = 1'b1;
        grant_idx_o = IDX_W'(j);
        any_grant_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/onehot_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module  : onehot_mux_pipe
// Brief   : Registered NUM_CH x BUS_SIZE one-hot multiplexer with a one-entry
//           valid/ready output stage. Selection is either a direct one-hot
//           select or a round-robin grant over request lines; failed
//           selections produce a zero beat flagged as an error.
// Revision: 1.0 - initial release
// ============================================================================
module onehot_mux_pipe
  import alu_mux_pkg::*;
#(
  parameter int BUS_SIZE  = 32,
  parameter int NUM_CH    = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*BUS_SIZE-1:0] in_bus,
  input  logic [NUM_CH-1:0]          sel,
  input  logic [NUM_CH-1:0]          req,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [BUS_SIZE-1:0]        out_data,
  output logic [NUM_CH-1:0]          out_sel,
  output logic                       out_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ERR_CNT_W-1:0]       err_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [BUS_SIZE-1:0]  out_data_q, out_data_d;
  logic [NUM_CH-1:0]    out_sel_q,  out_sel_d;
  logic                 out_err_q,  out_err_d;
  logic                 out_valid_q, out_valid_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;
  logic [IDX_W-1:0]     ptr_q,      ptr_d;

  logic                 in_fire;
  oh_class_e            sel_class;
  logic [NUM_CH-1:0]    rr_gnt;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_any;
  logic [NUM_CH-1:0]    grant;
  logic                 sel_err;
  logic [BUS_SIZE-1:0]  chan_masked [NUM_CH];
  logic [BUS_SIZE-1:0]  mux_data;

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;

  assign sel_class = is_onehot(32'(sel));

  rr_grant #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_grant (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .grant_o     (rr_gnt),
    .grant_idx_o (rr_idx),
    .any_grant_o (rr_any)
  );

  // Resolve the effective grant; a failed selection yields an empty grant
  always_comb begin
    grant   = '0;
    sel_err = 1'b1;
    if (mode == MODE_RR) begin
      grant   = rr_gnt;
      sel_err = !rr_any;
    end else if (sel_class == OH_ONE) begin
      grant   = sel;
      sel_err = 1'b0;
    end
  end

  // Per-channel AND stage of the AND-OR multiplexer
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign chan_masked[k] = in_bus[k*BUS_SIZE +: BUS_SIZE] & {BUS_SIZE{grant[k]}};
  end

  // OR stage: at most one masked channel is non-zero
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      mux_data = mux_data | chan_masked[k];
    end
  end

  // Next state of the output stage, pointer and error counter
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;
    ptr_d       = ptr_q;
    if (in_fire) begin
      out_data_d  = mux_data;
      out_sel_d   = grant;
      out_err_d   = sel_err;
      out_valid_d = 1'b1;
      if (sel_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if ((mode == MODE_RR) && rr_any) begin
        ptr_d = (rr_idx == IDX_W'(NUM_CH - 1)) ? '0 : rr_idx + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that discards any held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_onehot_mux_pipe
// Brief   : Directed self-checking bench for onehot_mux_pipe (16 x 32 bit,
//           2-bit error counter). Channel k carries 32'h1000_0000 + k.
// Revision: 1.0 - initial release
// ============================================================================
module tb_onehot_mux_pipe;

  localparam int BUS_SIZE  = 32;
  localparam int NUM_CH    = 16;
  localparam int ERR_CNT_W = 2;

  logic                       clk;
  logic                       rst;
  logic [NUM_CH*BUS_SIZE-1:0] in_bus;
  logic [NUM_CH-1:0]          sel;
  logic [NUM_CH-1:0]          req;
  logic                       mode;
  logic                       in_valid;
  logic                       in_ready;
  logic [BUS_SIZE-1:0]        out_data;
  logic [NUM_CH-1:0]          out_sel;
  logic                       out_err;
  logic                       out_valid;
  logic                       out_ready;
  logic [ERR_CNT_W-1:0]       err_cnt;

  int tests_run;
  int tests_failed;

  onehot_mux_pipe #(
    .BUS_SIZE  (BUS_SIZE),
    .NUM_CH    (NUM_CH),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .sel       (sel),
    .req       (req),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat with out_ready high and advance one edge
  task automatic beat(input logic m, input logic [15:0] s, input logic [15:0] r);
    mode      = m;
    sel       = s;
    req       = r;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; sel = 16'h0400; mode = 1'b0; out_ready = 1'b1;
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data got %h want 0", out_data); end
    tests_run++;
    if (out_sel !== 16'h0 || out_err !== 1'b0) begin tests_failed++; $display("FAIL reset_sel_err got %h/%b want 0/0", out_sel, out_err); end
    tests_run++;
    if (err_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_errcnt got %0d want 0", err_cnt); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_inready got %b want 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_direct();
    beat(1'b0, 16'h0400, 16'h0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h1000_000A || out_sel !== 16'h0400 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL direct_ch10 got v=%b d=%h s=%h e=%b want 1/1000000a/0400/0", out_valid, out_data, out_sel, out_err);
    end
    beat(1'b0, 16'h0001, 16'h0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h1000_0000 || out_sel !== 16'h0001 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL direct_ch0 got v=%b d=%h s=%h e=%b want 1/10000000/0001/0", out_valid, out_data, out_sel, out_err);
    end
    beat(1'b0, 16'h8000, 16'h0);
    tests_run++;
    if (out_data !== 32'h1000_000F || out_sel !== 16'h8000) begin
      tests_failed++;
      $display("FAIL direct_ch15 got d=%h s=%h want 1000000f/8000", out_data, out_sel);
    end
    // Idle cycle: held beat is drained, nothing new loaded
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 32'h1000_000F) begin
      tests_failed++;
      $display("FAIL drain_idle got v=%b d=%h want 0/1000000f", out_valid, out_data);
    end
  endtask

  task automatic test_bad_select();
    beat(1'b0, 16'h0005, 16'hFFFF);
    tests_run++;
    if (out_data !== 32'h0 || out_sel !== 16'h0 || out_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_multihot got d=%h s=%h e=%b want 0/0/1", out_data, out_sel, out_err);
    end
    beat(1'b0, 16'h0000, 16'hFFFF);
    tests_run++;
    if (out_data !== 32'h0 || out_sel !== 16'h0 || out_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_zero got d=%h s=%h e=%b want 0/0/1", out_data, out_sel, out_err);
    end
    tests_run++;
    if (err_cnt !== 2'd2) begin tests_failed++; $display("FAIL errcnt_two got %0d want 2", err_cnt); end
    beat(1'b0, 16'h0003, 16'h0);
    tests_run++;
    if (err_cnt !== 2'd3) begin tests_failed++; $display("FAIL errcnt_three got %0d want 3", err_cnt); end
    for (int i = 0; i < 3; i++) beat(1'b0, 16'hF000, 16'h0);
    tests_run++;
    if (err_cnt !== 2'd3) begin tests_failed++; $display("FAIL errcnt_sat got %0d want 3", err_cnt); end
    // A good beat clears the flag and leaves the counter alone
    beat(1'b0, 16'h0002, 16'h0);
    tests_run++;
    if (out_err !== 1'b0 || out_data !== 32'h1000_0001 || err_cnt !== 2'd3) begin
      tests_failed++;
      $display("FAIL good_after_bad got e=%b d=%h c=%0d want 0/10000001/3", out_err, out_data, err_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_sel [4];
    exp_sel[0] = 16'h0001; exp_sel[1] = 16'h0100; exp_sel[2] = 16'h8000; exp_sel[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 16'h0, 16'h8101);
      tests_run++;
      if (out_sel !== exp_sel[i] || out_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_seq%0d got s=%h e=%b want %h/0", i, out_sel, out_err, exp_sel[i]);
      end
    end
    tests_run++;
    if (out_data !== 32'h1000_0000) begin tests_failed++; $display("FAIL rr_data got %h want 10000000", out_data); end
    beat(1'b1, 16'h0, 16'h0000);
    tests_run++;
    if (out_err !== 1'b1 || out_sel !== 16'h0 || out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL rr_noreq got e=%b s=%h d=%h want 1/0/0", out_err, out_sel, out_data);
    end
    // Pointer must still be 1 after the empty request
    beat(1'b1, 16'h0, 16'h8101);
    tests_run++;
    if (out_sel !== 16'h0100 || out_data !== 32'h1000_0008) begin
      tests_failed++;
      $display("FAIL rr_after_noreq got s=%h d=%h want 0100/10000008", out_sel, out_data);
    end
  endtask

  task automatic test_backpressure();
    beat(1'b0, 16'h0008, 16'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      mode     = i[0];
      sel      = 16'h0001 << i;
      req      = 16'hFFFF >> i;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_inready%0d got %b want 0", i, in_ready); end
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'h1000_0003 || out_sel !== 16'h0008 || out_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d got v=%b d=%h s=%h e=%b want 1/10000003/0008/0", i, out_valid, out_data, out_sel, out_err);
      end
    end
    mode = 1'b0; sel = 16'h0002; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h1000_0001 || out_sel !== 16'h0002) begin
      tests_failed++;
      $display("FAIL bp_replace got v=%b d=%h s=%h want 1/10000001/0002", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_reset_mid();
    // Pointer is 9 here; request 4 alone gives grant 4, pointer becomes 5
    beat(1'b1, 16'h0, 16'h0010);
    tests_run++;
    if (out_sel !== 16'h0010 || out_data !== 32'h1000_0004) begin
      tests_failed++;
      $display("FAIL mid_setup got s=%h d=%h want 0010/10000004", out_sel, out_data);
    end
    out_ready = 1'b0; in_valid = 1'b1; req = 16'hFFFF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_sel !== 16'h0 || out_data !== 32'h0 || err_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset got v=%b s=%h d=%h c=%0d want 0/0/0/0", out_valid, out_sel, out_data, err_cnt);
    end
    beat(1'b1, 16'h0, 16'hFFFF);
    tests_run++;
    if (out_sel !== 16'h0001 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_ptr0 got s=%h v=%b want 0001/1", out_sel, out_valid);
    end
    beat(1'b1, 16'h0, 16'hFFFF);
    tests_run++;
    if (out_sel !== 16'h0002) begin tests_failed++; $display("FAIL mid_ptr1 got s=%h want 0002", out_sel); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int k = 0; k < NUM_CH; k++) in_bus[k*BUS_SIZE +: BUS_SIZE] = 32'h1000_0000 + 32'(k);
    rst = 1'b1; sel = '0; req = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_direct();
    test_bad_select();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
